// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO/LIFO family.
//   clog2    : ceiling log2, usable in parameter expressions
//   is_pow2  : depth legality check used at elaboration
//   ptr_w    : pointer width for a given depth (clog2(DEPTH))
//   cnt_w    : occupancy counter width (ptr_w + 1, holds 0..DEPTH)
package fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array, one synchronous write port and one
// registered read port. Storage is not reset; only the read register is.
//   clk, rst_n         : clock, async active-low reset (read register only)
//   we, waddr, wdata   : write port, written on the rising edge when we=1
//   re, raddr, rdata   : read port, rdata loads mem[raddr] when re=1, else holds
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  localparam int AW    = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DATA_W-1:0]            rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Same-address read+write (FIFO full) returns the old word: NBA ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow and a one-cycle read-data valid strobe.
//   clk, rst_n              : clock, async active-low reset
//   wr_en, dataIn           : write request and data
//   rd_en                   : read request
//   dataOut, dataOut_valid  : registered read data, strobe on accepted read
//   empty, full             : count == 0 / count == DEPTH
//   almost_empty/full       : count <= AE_LEVEL / count >= AF_LEVEL
//   count                   : occupancy 0..DEPTH
//   overflow, underflow     : sticky rejected-write / rejected-read
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       dataIn,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       dataOut,
  output logic                    dataOut_valid,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, vld_q;
  logic             wr_acc, rd_acc;

  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CNT_W'(DEPTH));
    almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  end

  // A write into a full FIFO is fine if a read frees a slot the same edge.
  always_comb begin
    rd_acc   = rd_en & ~empty;
    wr_acc   = wr_en & (~full | rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (wr_en & ~wr_acc);
    udf_d = udf_q | (rd_en & ~rd_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      vld_q    <= rd_acc;
    end
  end

  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (dataIn),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (dataOut)
  );

  assign dataOut_valid = vld_q;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0] dataIn = '0;
  logic [3:0] dataOut;
  logic       dataOut_valid, empty, full, almost_empty, almost_full;
  logic [2:0] count;
  logic       overflow, underflow;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_W(4), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .dataIn(dataIn), .rd_en(rd_en),
    .dataOut(dataOut), .dataOut_valid(dataOut_valid), .empty(empty),
    .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  typedef struct {
    logic       wr;
    logic       rd;
    logic [3:0] din;
    logic [3:0] ed;
    logic       ev;
    int         ec;
    logic       eo;
    logic       eu;
  } vec_t;

  // Flags are derived from the expected occupancy by the threshold rules.
  task automatic chk(input string nm, input logic [3:0] ed, input logic ev,
                     input int ec, input logic eo, input logic eu);
    logic [13:0] exp_v, act_v;
    exp_v = {ed, ev, 1'(ec == 0), 1'(ec == DEPTH), 1'(ec <= AE), 1'(ec >= AF),
             3'(ec), eo, eu};
    act_v = {dataOut, dataOut_valid, empty, full, almost_empty, almost_full,
             count, overflow, underflow};
    n_tot++;
    if (act_v !== exp_v)
      $display("FAIL %s: got {dout,vld,emp,full,ae,af,cnt,ovf,udf}=%b required %b",
               nm, act_v, exp_v);
    else
      n_pass++;
  endtask

  task automatic step(input logic w, input logic r, input logic [3:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; dataIn = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  // Assert reset between edges, check asynchronously, release on a negedge.
  task automatic do_reset(input string nm);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk(nm, 4'h0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[11];

  initial begin
    tbl = '{
      '{1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 4'h2, 4'h0, 1'b0, 2, 1'b0, 1'b0},
      '{1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 3, 1'b0, 1'b0},
      '{1'b1, 1'b0, 4'h4, 4'h0, 1'b0, 4, 1'b0, 1'b0},
      '{1'b1, 1'b0, 4'h9, 4'h0, 1'b0, 4, 1'b1, 1'b0},
      '{1'b0, 1'b1, 4'h0, 4'h1, 1'b1, 3, 1'b1, 1'b0},
      '{1'b0, 1'b1, 4'h0, 4'h2, 1'b1, 2, 1'b1, 1'b0},
      '{1'b0, 1'b1, 4'h0, 4'h3, 1'b1, 1, 1'b1, 1'b0},
      '{1'b0, 1'b1, 4'h0, 4'h4, 1'b1, 0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 4'h0, 4'h4, 1'b0, 0, 1'b1, 1'b1},
      '{1'b0, 1'b0, 4'h0, 4'h4, 1'b0, 0, 1'b1, 1'b1}
    };

    // Power-on reset
    #1 chk("por", 4'h0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, overflow, drain, underflow
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("tbl[%0d]", i), tbl[i].ed, tbl[i].ev, tbl[i].ec, tbl[i].eo, tbl[i].eu);
    end

    // Simultaneous read+write at full, then at empty
    do_reset("rst_a");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'(i + 5));
    chk("fill_b", 4'h0, 1'b0, 4, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'hA);
    chk("rw_full", 4'h5, 1'b1, 4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h0); chk("drain6", 4'h6, 1'b1, 3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h0); chk("drain7", 4'h7, 1'b1, 2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h0); chk("drain8", 4'h8, 1'b1, 1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h0); chk("drainA", 4'hA, 1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'hB);
    chk("rw_empty", 4'hA, 1'b0, 1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'h0); chk("readB", 4'hB, 1'b1, 0, 1'b0, 1'b1);

    // Pointer wrap with occupancy held at 2
    do_reset("rst_w");
    step(1'b1, 1'b0, 4'h0); chk("wrap_w0", 4'h0, 1'b0, 1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h1); chk("wrap_w1", 4'h0, 1'b0, 2, 1'b0, 1'b0);
    for (int k = 2; k < 10; k++) begin
      step(1'b1, 1'b1, 4'(k));
      chk($sformatf("wrap_rw%0d", k), 4'(k - 2), 1'b1, 2, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 4'h0); chk("wrap_r8", 4'h8, 1'b1, 1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h0); chk("wrap_r9", 4'h9, 1'b1, 0, 1'b0, 1'b0);

    // Asynchronous reset mid-operation with count = 3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'(i + 1));
    step(1'b0, 1'b1, 4'h0);
    step(1'b1, 1'b0, 4'h7);
    chk("pre_async", 4'h1, 1'b0, 3, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 4'h0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'hC); chk("post_wC", 4'h0, 1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h0); chk("post_rC", 4'hC, 1'b1, 0, 1'b0, 1'b0);

    // Randomised traffic against a queue model
    begin
      logic [3:0] q[$];
      logic [3:0] mdout;
      logic       mvld, movf, mudf, w, r, rok, wok;
      logic [3:0] d;
      do_reset("rst_r");
      mdout = '0; movf = 1'b0; mudf = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (i == 200) begin
          do_reset("rst_mid");
          q.delete(); mdout = '0; movf = 1'b0; mudf = 1'b0;
        end
        w = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        d = 4'($urandom);
        rok = r && (q.size() > 0);
        wok = w && (q.size() < DEPTH || rok);
        if (r && !rok) mudf = 1'b1;
        if (w && !wok) movf = 1'b1;
        mvld = rok;
        if (rok) mdout = q.pop_front();
        if (wok) q.push_back(d);
        step(w, r, d);
        chk($sformatf("rand%0d", i), mdout, mvld, q.size(), movf, mudf);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
